// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: opcode constants, pipeline depth
// bounds, control-bundle layout and FSM state encoding.
package ctrl_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [11:0] FUNC12_MRET = 12'h302;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       auipc;
    logic       csr;
    logic       csr_imm;
    logic       mret;
    logic       us;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_bundle_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic opcode_legal(input logic [4:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational RV32 control decode producing one control bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [4:0]  opc_s;
  logic [2:0]  grp_s;
  logic [2:0]  func3_s;
  logic [11:0] func12_s;
  logic        sys_s;
  logic        jal_s;
  logic        jalr_s;
  logic        ill_s;
  logic        unused_s;

  assign opc_s    = instr[6:2];
  assign grp_s    = opc_s[4:2];
  assign func3_s  = instr[14:12];
  assign func12_s = instr[31:20];
  assign sys_s    = (opc_s == OPC_SYSTEM);
  assign jal_s    = (opc_s == OPC_JAL);
  assign jalr_s   = (opc_s == OPC_JALR);
  assign ill_s    = (instr[1:0] != 2'b11) || !opcode_legal(opc_s);
  // Register-index fields play no part in control decode.
  assign unused_s = ^{instr[19:15], instr[11:7]};

  // Raw group decode, then squash side-effecting controls on illegal words.
  always_comb begin
    ctrl            = '0;
    ctrl.branch     = (grp_s == 3'd6);
    ctrl.mem_read   = (grp_s == 3'd0);
    ctrl.mem_to_reg = (grp_s == 3'd0);
    ctrl.mem_write  = (grp_s == 3'd2);
    ctrl.alu_op[1]  = (grp_s == 3'd3) || (grp_s == 3'd1);
    ctrl.alu_op[0]  = (grp_s == 3'd6) || (grp_s == 3'd1);
    ctrl.alu_src    = (grp_s == 3'd0) || (grp_s == 3'd2) || (grp_s == 3'd1) ||
                      (opc_s == OPC_LUI);
    ctrl.reg_write  = (grp_s == 3'd0) || (grp_s == 3'd1) || (grp_s == 3'd3) ||
                      jal_s || jalr_s || sys_s;
    ctrl.jump       = jal_s || jalr_s;
    ctrl.auipc      = (opc_s == OPC_AUIPC);
    ctrl.csr        = sys_s;
    ctrl.csr_imm    = sys_s && func3_s[2];
    ctrl.us         = func3_s[2];
    ctrl.mret       = sys_s && (func3_s == 3'd0) && (func12_s == FUNC12_MRET);
    ctrl.illegal    = ill_s;
    if (ill_s) begin
      ctrl.branch     = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.reg_write  = 1'b0;
      ctrl.jump       = 1'b0;
      ctrl.csr        = 1'b0;
      ctrl.csr_imm    = 1'b0;
      ctrl.mret       = 1'b0;
    end else begin
      ctrl.illegal    = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Elastic control-decode pipeline: decodes at the input, carries the bundle
// through STAGES registered stages and serialises SYSTEM instructions.
module ctrl_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int STAGES        = 2,
  parameter bit SERIALIZE_CSR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic        jump,
  output logic        auipc,
  output logic        csr,
  output logic        csr_imm,
  output logic        mret,
  output logic        us,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        busy
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("ctrl_unit_pipe: STAGES out of range");
  end

  ctrl_bundle_t      dec_s;
  ctrl_bundle_t      data_q [STAGES];
  ctrl_bundle_t      data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] take_s;
  state_e            state_q;
  state_e            state_d;
  logic              accept_s;
  logic              out_fire_s;

  ctrl_decode u_decode (
    .instr (instr),
    .ctrl  (dec_s)
  );

  // Stage i can load when it is empty or its occupant moves on this cycle.
  always_comb begin
    logic t;
    take_s         = '0;
    t              = !valid_q[STAGES-1] || out_ready;
    take_s[STAGES-1] = t;
    for (int i = STAGES - 2; i >= 0; i--) begin
      t         = !valid_q[i] || t;
      take_s[i] = t;
    end
  end

  assign in_ready   = take_s[0] && (state_q == ST_RUN) && !flush;
  assign accept_s   = in_valid && in_ready;
  assign out_fire_s = valid_q[STAGES-1] && out_ready;

  // Pipeline next state; empty stages hold an all-zero bundle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) begin
        data_d[i] = ctrl_bundle_t'('0);
      end
    end else begin
      if (take_s[0]) begin
        valid_d[0] = accept_s;
        data_d[0]  = accept_s ? dec_s : ctrl_bundle_t'('0);
      end else begin
        valid_d[0] = valid_q[0];
      end
      for (int i = 1; i < STAGES; i++) begin
        if (take_s[i]) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end else begin
          valid_d[i] = valid_q[i];
        end
      end
    end
  end

  // RUN/DRAIN next state: a SYSTEM instr blocks intake until it leaves.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (SERIALIZE_CSR && accept_s && dec_s.csr) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (out_fire_s && data_q[STAGES-1].csr) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= ctrl_bundle_t'('0);
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign branch     = data_q[STAGES-1].branch;
  assign mem_read   = data_q[STAGES-1].mem_read;
  assign mem_to_reg = data_q[STAGES-1].mem_to_reg;
  assign mem_write  = data_q[STAGES-1].mem_write;
  assign alu_src    = data_q[STAGES-1].alu_src;
  assign reg_write  = data_q[STAGES-1].reg_write;
  assign jump       = data_q[STAGES-1].jump;
  assign auipc      = data_q[STAGES-1].auipc;
  assign csr        = data_q[STAGES-1].csr;
  assign csr_imm    = data_q[STAGES-1].csr_imm;
  assign mret       = data_q[STAGES-1].mret;
  assign us         = data_q[STAGES-1].us;
  assign alu_op     = data_q[STAGES-1].alu_op;
  assign illegal    = data_q[STAGES-1].illegal;
  assign busy       = (|valid_q) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed bench for ctrl_unit_pipe: decode vector table plus hand-written
// sequences for serialisation, backpressure, flush and reset.
module tb_ctrl_unit_pipe;

  localparam int STAGES = 2;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic        jump, auipc, csr, csr_imm, mret, us, illegal, busy;
  logic [1:0]  alu_op;
  logic [14:0] obs_s;

  int n_tests = 0;
  int n_fail  = 0;

  ctrl_unit_pipe #(.STAGES(STAGES), .SERIALIZE_CSR(1'b1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .branch(branch), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .jump(jump), .auipc(auipc), .csr(csr),
    .csr_imm(csr_imm), .mret(mret), .us(us), .alu_op(alu_op),
    .illegal(illegal), .busy(busy)
  );

  assign obs_s = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
                  jump, auipc, csr, csr_imm, mret, us, alu_op, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [14:0] mk(input logic b, mr, mtr, mw, asrc, rw, j,
                                     au, c, ci, m, u, input logic [1:0] op,
                                     input logic il);
    return {b, mr, mtr, mw, asrc, rw, j, au, c, ci, m, u, op, il};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nout;
    logic acc;
    logic [14:0] expq [3];

    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; flush = 1'b0; out_ready = 1'b1;

    //                          b  mr mtr mw as rw j  au c  ci m  u  op     il
    vecs[0]  = '{32'h00500093, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b11, 0), "addi"};
    vecs[1]  = '{32'h00012083, mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0), "lw"};
    vecs[2]  = '{32'h00112023, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "sw"};
    vecs[3]  = '{32'h002081B3, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0), "add"};
    vecs[4]  = '{32'h00208463, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0), "beq"};
    vecs[5]  = '{32'h123450B7, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2'b10, 0), "lui"};
    vecs[6]  = '{32'h00001097, mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 2'b11, 0), "auipc"};
    vecs[7]  = '{32'h010000EF, mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 0), "jal"};
    vecs[8]  = '{32'h000100E7, mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 0), "jalr"};
    vecs[9]  = '{32'h30011073, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0), "csrrw"};
    vecs[10] = '{32'h3002D0F3, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 2'b00, 0), "csrrwi"};
    vecs[11] = '{32'h30200073, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 2'b00, 0), "mret"};
    vecs[12] = '{32'h00000073, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0), "ecall"};
    vecs[13] = '{32'h00000000, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), "zero"};
    vecs[14] = '{32'h0000000F, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), "fence_ill"};
    vecs[15] = '{32'h0000007F, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), "opc1f_ill"};
    vecs[16] = '{32'h00500091, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1), "addi_lo01"};
    vecs[17] = '{32'h00014083, mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0), "lbu"};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ctrl", {17'd0, obs_s}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Decode table: single issue, exact latency, no backpressure
    foreach (vecs[v]) begin
      in_valid = 1'b1;
      instr    = vecs[v].instr;
      @(negedge clk);
      chk({vecs[v].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        @(negedge clk);
        if (k < STAGES) begin
          chk({vecs[v].name, "_early"}, {31'd0, out_valid}, 32'd0);
          chk({vecs[v].name, "_zero"}, {17'd0, obs_s}, 32'd0);
        end else begin
          chk({vecs[v].name, "_valid"}, {31'd0, out_valid}, 32'd1);
          chk({vecs[v].name, "_ctrl"}, {17'd0, obs_s}, {17'd0, vecs[v].exp});
        end
        tick();
      end
    end

    // mret serialisation: intake blocked until its output handshake
    in_valid = 1'b1; instr = vecs[11].instr;
    @(negedge clk);
    chk("b_acc_mret", {31'd0, in_ready}, 32'd1);
    tick();
    instr = vecs[0].instr;
    @(negedge clk);
    chk("b_block1", {31'd0, in_ready}, 32'd0);
    chk("b_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("b_block2", {31'd0, in_ready}, 32'd0);
    chk("b_mret_out", {17'd0, obs_s}, {17'd0, vecs[11].exp});
    chk("b_mret_valid", {31'd0, out_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("b_reopen", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_gap", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("b_addi_out", {17'd0, obs_s}, {17'd0, vecs[0].exp});
    tick();

    // Backpressure: three instrs, output stalled for five cycles
    expq[0] = vecs[1].exp; expq[1] = vecs[2].exp; expq[2] = vecs[3].exp;
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[1].instr;
    @(negedge clk);
    chk("c_acc0", {31'd0, in_ready}, 32'd1);
    tick();
    instr = vecs[2].instr;
    @(negedge clk);
    chk("c_acc1", {31'd0, in_ready}, 32'd1);
    tick();
    instr = vecs[3].instr;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("c_stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("c_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("c_stall_hold", {17'd0, obs_s}, {17'd0, expq[0]});
      tick();
    end
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 20 && nout < 3; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk("c_order", {17'd0, obs_s}, {17'd0, expq[nout]});
        nout++;
      end
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("c_drain_count", nout, 32'd3);
    @(negedge clk);
    chk("c_no_dup", {31'd0, out_valid}, 32'd0);
    tick();

    // Flush during DRAIN with two entries held
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[0].instr;
    @(negedge clk);
    chk("d_acc0", {31'd0, in_ready}, 32'd1);
    tick();
    instr = vecs[9].instr;
    @(negedge clk);
    chk("d_acc1", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("d_drain_busy", {31'd0, busy}, 32'd1);
    chk("d_drain_blocked", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("d_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("d_flush_busy", {31'd0, busy}, 32'd0);
    chk("d_flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("d_flush_ctrl", {17'd0, obs_s}, 32'd0);
    in_valid = 1'b1; instr = vecs[0].instr; flush = 1'b1;
    @(negedge clk);
    chk("d_flush_gate", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("d_flush_no_acc", {31'd0, busy}, 32'd0);
    tick();

    // Reset with the pipe full: nothing may emerge afterwards
    out_ready = 1'b0; in_valid = 1'b1; instr = vecs[3].instr;
    tick();
    instr = vecs[1].instr;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("e_full_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("e_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("e_rst_ctrl", {17'd0, obs_s}, 32'd0);
    chk("e_rst_busy", {31'd0, busy}, 32'd0);
    chk("e_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      chk("e_discarded", {31'd0, out_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
